// File: rtl/clk_fwd_pkg.sv
// Shared state type and default sizing for the debug clock-forwarding sequencer.
package clk_fwd_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    DRAIN     = 2'd3
  } fwd_state_t;

  localparam int DIV_W_DEF     = 4;
  localparam int LOCK_WAIT_DEF = 1024;
  localparam int CW_DEF        = 11;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_p0, sync_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/clk_fwd_ctrl.sv
// Debug differential clock forwarding sequencer driving ODDR d1/d2/ce.
// Define CLK_FWD_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module clk_fwd_ctrl
  import clk_fwd_pkg::*;
#(
  parameter int LOCK_WAIT = LOCK_WAIT_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             fwd_en,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             clr_lock_lost,
  output logic             oddr_d1,
  output logic             oddr_d2,
  output logic             oddr_ce,
  output logic             fwd_active,
`ifdef CLK_FWD_LOSS_CNT_EN
  output logic [7:0]       lock_loss_cnt,
`endif
  output logic             lock_lost
);
  localparam int HW = DIV_W + 1;

  fwd_state_t    state;
  logic          lock_s;
  logic [CW-1:0] lock_cnt;
  logic [HW-1:0] h, n_cur, n_use, h_nxt;
  logic [HW:0]   h_p2;
  logic          d1_nxt, d2_nxt, lost_evt, stop;

  function automatic logic half_hi(input logic [HW-1:0] idx, input logic [HW-1:0] n);
    return idx < n;
  endfunction

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // h is the next even half-cycle to emit; h == 0 marks a period boundary where N is re-latched
  always_comb begin
    n_use    = (h == '0) ? (HW'(div_sel) + HW'(1)) : n_cur;
    h_p2     = {1'b0, h} + (HW+1)'(2);
    h_nxt    = (h_p2 == {n_use, 1'b0}) ? '0 : h_p2[HW-1:0];
    d1_nxt   = half_hi(h, n_use);
    d2_nxt   = half_hi(h + HW'(1), n_use);
    lost_evt = ((state == RUN) || (state == DRAIN)) && !lock_s;
    stop     = (state == DRAIN) || !fwd_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      h          <= '0;
      n_cur      <= '0;
      oddr_d1    <= 1'b0;
      oddr_d2    <= 1'b0;
      oddr_ce    <= 1'b0;
      fwd_active <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      oddr_d1    <= 1'b0;
      oddr_d2    <= 1'b0;
      oddr_ce    <= 1'b0;
      fwd_active <= 1'b0;
      if (lost_evt)
        lock_lost <= 1'b1;
      else if (clr_lock_lost)
        lock_lost <= 1'b0;

      case (state)
        IDLE: begin
          h <= '0;
          if (fwd_en) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
          end
        end
        WAIT_LOCK: begin
          if (!fwd_en) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (!lock_s) begin
            lock_cnt <= '0;
          end else if (lock_cnt == CW'(LOCK_WAIT - 1)) begin
            state      <= RUN;
            lock_cnt   <= '0;
            oddr_ce    <= 1'b1;
            fwd_active <= 1'b1;
            oddr_d1    <= d1_nxt;
            oddr_d2    <= d2_nxt;
            h          <= h_nxt;
            n_cur      <= n_use;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: begin
          // Lock loss beats a falling fwd_en: stop immediately rather than drain
          if (lost_evt) begin
            state    <= fwd_en ? WAIT_LOCK : IDLE;
            h        <= '0;
            lock_cnt <= '0;
          end else if (stop && (h == '0)) begin
            state <= IDLE;
          end else begin
            state      <= stop ? DRAIN : RUN;
            oddr_ce    <= 1'b1;
            fwd_active <= !stop;
            oddr_d1    <= d1_nxt;
            oddr_d2    <= d2_nxt;
            h          <= h_nxt;
            n_cur      <= n_use;
          end
        end
      endcase
    end
  end

`ifdef CLK_FWD_LOSS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lock_loss_cnt <= '0;
    else if (lost_evt) begin
      if (lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end else if (clr_lock_lost)
      lock_loss_cnt <= '0;
  end
`endif
endmodule

// File: tb/tb_clk_fwd_ctrl.sv
// Self-checking bench for clk_fwd_ctrl; honours CLK_FWD_LOSS_CNT_EN when defined.
module tb_clk_fwd_ctrl;
  localparam int LW    = 16;
  localparam int DIV_W = 4;

  logic             clk = 1'b0, rst = 1'b0, locked = 1'b0, fwd_en = 1'b0, clr_lock_lost = 1'b0;
  logic [DIV_W-1:0] div_sel = '0;
  logic             oddr_d1, oddr_d2, oddr_ce, fwd_active, lock_lost;
`ifdef CLK_FWD_LOSS_CNT_EN
  logic [7:0]       lock_loss_cnt;
`endif

  int asserts = 0;
  int fails   = 0;

  clk_fwd_ctrl #(.LOCK_WAIT(LW), .DIV_W(DIV_W), .CW(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .fwd_en        (fwd_en),
    .div_sel       (div_sel),
    .clr_lock_lost (clr_lock_lost),
    .oddr_d1       (oddr_d1),
    .oddr_d2       (oddr_d2),
    .oddr_ce       (oddr_ce),
    .fwd_active    (fwd_active),
`ifdef CLK_FWD_LOSS_CNT_EN
    .lock_loss_cnt (lock_loss_cnt),
`endif
    .lock_lost     (lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Reference model: forwarded waveform is a queue of half-cycle bits, refilled a period at a time
  localparam int M_OFF = 0, M_WAIT = 1, M_RUN = 2, M_DRAIN = 3;
  int m_mode, m_streak, e_cnt, cyc;
  bit e_d1, e_d2, e_ce, e_act, e_lost;
  bit lk_hist[$];
  bit wave[$];

  task automatic model_reset();
    m_mode = M_OFF; m_streak = 0; e_cnt = 0;
    e_d1 = 0; e_d2 = 0; e_ce = 0; e_act = 0; e_lost = 0;
    lk_hist.delete(); lk_hist.push_back(1'b0); lk_hist.push_back(1'b0);
    wave.delete();
  endtask

  task automatic emit();
    int n;
    if (wave.size() == 0) begin
      n = int'(div_sel) + 1;
      for (int i = 0; i < n; i++) wave.push_back(1'b1);
      for (int i = 0; i < n; i++) wave.push_back(1'b0);
    end
    e_d1  = wave.pop_front();
    e_d2  = wave.pop_front();
    e_ce  = 1'b1;
    e_act = (m_mode == M_RUN);
  endtask

  task automatic model_step();
    bit ls, lost_ev, stop;
    cyc++;
    ls = lk_hist.pop_front();
    lk_hist.push_back(locked);
    lost_ev = ((m_mode == M_RUN) || (m_mode == M_DRAIN)) && !ls;
    if (lost_ev) begin
      e_lost = 1'b1;
      if (e_cnt < 255) e_cnt++;
    end else if (clr_lock_lost) begin
      e_lost = 1'b0;
      e_cnt  = 0;
    end
    e_d1 = 0; e_d2 = 0; e_ce = 0; e_act = 0;
    if (m_mode == M_OFF) begin
      if (fwd_en) begin m_mode = M_WAIT; m_streak = 0; end
    end else if (m_mode == M_WAIT) begin
      if (!fwd_en) m_mode = M_OFF;
      else if (!ls) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == LW) begin m_mode = M_RUN; wave.delete(); emit(); end
      end
    end else if (lost_ev) begin
      m_mode = fwd_en ? M_WAIT : M_OFF;
      m_streak = 0;
      wave.delete();
    end else begin
      stop = (m_mode == M_DRAIN) || !fwd_en;
      if (wave.size() == 0 && stop) m_mode = M_OFF;
      else begin
        m_mode = stop ? M_DRAIN : M_RUN;
        emit();
      end
    end
  endtask

  function automatic logic [4:0] obs_vec();
    return {oddr_d1, oddr_d2, oddr_ce, fwd_active, lock_lost};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {e_d1, e_d2, e_ce, e_act, e_lost};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; fwd_en = 1'b0; locked = 1'b0; clr_lock_lost = 1'b0; div_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    asserts++;
    if (obs_vec() !== 5'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected 00000", obs_vec());
    end
`ifdef CLK_FWD_LOSS_CNT_EN
    asserts++;
    if (lock_loss_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d expected 0", lock_loss_cnt);
    end
`endif
  endtask

  // Starts from reset with locked and fwd_en raised together, checks latency and pattern table
  task automatic test_pattern(input string name, input int dsel, input logic [7:0] tbl, input int len);
    int rise;
    logic [1:0] want;
    do_reset();
    locked = 1'b1; fwd_en = 1'b1; div_sel = DIV_W'(dsel);
    rise = 0;
    for (int k = 1; k <= 40 && rise == 0; k++) begin
      tick();
      asserts++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL %s_startup cyc=%0d: got %b expected %b", name, cyc, obs_vec(), exp_vec());
      end
      if (oddr_ce) rise = k;
    end
    asserts++;
    if (rise != 2 + LW) begin
      fails++; $display("FAIL %s_latency: got %0d cycles expected %0d", name, rise, 2 + LW);
    end
    for (int k = 0; k < 2 * len + 1; k++) begin
      if (k > 0) tick();
      want = tbl[7 - 2 * (k % len) -: 2];
      asserts++;
      if ({oddr_d1, oddr_d2} !== want || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL %s_pattern k=%0d: got %b%b expected %b (model %b)", name, k, oddr_d1, oddr_d2, want, exp_vec());
      end
    end
    fwd_en = 1'b0;
    for (int k = 0; k < 40 && oddr_ce; k++) begin
      tick();
      asserts++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL %s_stop cyc=%0d: got %b expected %b", name, cyc, obs_vec(), exp_vec());
      end
    end
    asserts++;
    if (oddr_ce !== 1'b0) begin
      fails++; $display("FAIL %s_stopped: ce got %b expected 0", name, oddr_ce);
    end
  endtask

  task automatic start_fwd(input int dsel);
    do_reset();
    locked = 1'b1; fwd_en = 1'b1; div_sel = DIV_W'(dsel);
    for (int k = 0; k < 40 && !oddr_ce; k++) tick();
  endtask

  task automatic test_div_change();
    logic [1:0] seq [6] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    start_fwd(1);
    asserts++;
    if ({oddr_ce, oddr_d1, oddr_d2} !== 3'b111) begin
      fails++; $display("FAIL divchg_first: got %b expected 111", {oddr_ce, oddr_d1, oddr_d2});
    end
    div_sel = DIV_W'(3);
    for (int k = 0; k < 6; k++) begin
      tick();
      asserts++;
      if ({oddr_d1, oddr_d2} !== seq[k] || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL divchg k=%0d: got %b%b expected %b (model %b)", k, oddr_d1, oddr_d2, seq[k], exp_vec());
      end
    end
  endtask

  task automatic test_drain();
    logic [2:0] seq [4] = '{3'b111, 3'b100, 3'b100, 3'b000};
    start_fwd(3);
    fwd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      asserts++;
      if ({oddr_ce, oddr_d1, oddr_d2} !== seq[k] || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL drain k=%0d: got %b expected %b (model %b)", k, {oddr_ce, oddr_d1, oddr_d2}, seq[k], exp_vec());
      end
    end
    asserts++;
    if (fwd_active !== 1'b0) begin
      fails++; $display("FAIL drain_active: got %b expected 0", fwd_active);
    end
  endtask

  task automatic test_lock_loss();
    int rise;
    start_fwd(2);
    repeat (2) tick();
    locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      asserts++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL loss1 cyc=%0d: got %b expected %b", cyc, obs_vec(), exp_vec());
      end
    end
    asserts++;
    if ({oddr_d1, oddr_d2, oddr_ce, lock_lost} !== 4'b0001) begin
      fails++; $display("FAIL loss1_stop: got %b expected 0001", {oddr_d1, oddr_d2, oddr_ce, lock_lost});
    end
    locked = 1'b1;
    rise = 0;
    for (int k = 1; k <= 40 && rise == 0; k++) begin
      tick();
      asserts++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL relock cyc=%0d: got %b expected %b", cyc, obs_vec(), exp_vec());
      end
      if (oddr_ce) rise = k;
    end
    asserts++;
    if (rise != 2 + LW) begin
      fails++; $display("FAIL relock_latency: got %0d expected %0d", rise, 2 + LW);
    end
`ifdef CLK_FWD_LOSS_CNT_EN
    asserts++;
    if (lock_loss_cnt !== 8'd1) begin
      fails++; $display("FAIL loss_cnt1: got %0d expected 1", lock_loss_cnt);
    end
`endif
    locked = 1'b0;
    repeat (2) tick();
    clr_lock_lost = 1'b1;
    tick();
    clr_lock_lost = 1'b0;
    asserts++;
    if (lock_lost !== 1'b1 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL loss2_clr_coincide: lost got %b expected 1", lock_lost);
    end
`ifdef CLK_FWD_LOSS_CNT_EN
    asserts++;
    if (lock_loss_cnt !== 8'd2) begin
      fails++; $display("FAIL loss_cnt2: got %0d expected 2", lock_loss_cnt);
    end
`endif
    clr_lock_lost = 1'b1;
    tick();
    clr_lock_lost = 1'b0;
    asserts++;
    if (lock_lost !== 1'b0) begin
      fails++; $display("FAIL clr: lost got %b expected 0", lock_lost);
    end
`ifdef CLK_FWD_LOSS_CNT_EN
    asserts++;
    if (lock_loss_cnt !== 8'd0) begin
      fails++; $display("FAIL clr_cnt: got %0d expected 0", lock_loss_cnt);
    end
`endif
    // fwd_en falls on the same edge the loss is seen: immediate stop, flag set, back to idle
    locked = 1'b1;
    for (int k = 0; k < 40 && !oddr_ce; k++) tick();
    locked = 1'b0;
    repeat (2) tick();
    fwd_en = 1'b0;
    tick();
    locked = 1'b1;
    asserts++;
    if ({oddr_ce, lock_lost} !== 2'b01 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL simul_loss: ce/lost got %b expected 01", {oddr_ce, lock_lost});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      asserts++;
      if (oddr_ce !== 1'b0 || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL simul_idle k=%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    start_fwd(0);
    repeat (2) tick();
    asserts++;
    if (oddr_ce !== 1'b1) begin
      fails++; $display("FAIL areset_pre: ce got %b expected 1", oddr_ce);
    end
    #2;
    rst = 1'b0;
    #1;
    asserts++;
    if (obs_vec() !== 5'b0) begin
      fails++; $display("FAIL areset_outputs: got %b expected 00000", obs_vec());
    end
  endtask

  task automatic test_random();
    int low_left;
    do_reset();
    fwd_en = 1'b1;
    low_left = 0;
    for (int k = 0; k < 4000; k++) begin
      if (low_left > 0) begin
        locked = 1'b0; low_left--;
      end else begin
        locked = 1'b1;
        if ($urandom_range(0, 199) == 0) low_left = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 59) == 0) fwd_en = !fwd_en;
      if ($urandom_range(0, 9) == 0) div_sel = DIV_W'($urandom_range(0, 15));
      clr_lock_lost = ($urandom_range(0, 39) == 0);
      tick();
      asserts++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d: got %b expected %b", cyc, obs_vec(), exp_vec());
      end
`ifdef CLK_FWD_LOSS_CNT_EN
      asserts++;
      if (lock_loss_cnt !== 8'(e_cnt)) begin
        fails++; $display("FAIL random_cnt cyc=%0d: got %0d expected %0d", cyc, lock_loss_cnt, e_cnt);
      end
`endif
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_pattern("n1", 0, 8'b10_000000, 1);
    test_pattern("n3", 2, 8'b11_10_00_00, 3);
    test_pattern("n2", 1, 8'b11_00_0000, 2);
    test_div_change();
    test_drain();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
